clk_div_odd_or: RTL and testbench

CLK_DIV_ODD_OR -- requirements
Module: clk_div_odd_or

---
 rtl/clk_div_odd_or_if.sv | 15 +
 rtl/clk_div_odd_or.sv | 84 ++++++++
 tb/tb_clk_div_odd_or.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_odd_or_if.sv
// ---------------------------------------------------------------------------
// clk_div_odd_or_if : carries the divided clock from the divider to its users
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface clk_div_odd_or_if;
  logic clk_div9;

  modport master (output clk_div9);
  modport slave  (input  clk_div9);
endinterface

`default_nettype wire

// File: rtl/clk_div_odd_or.sv
// ---------------------------------------------------------------------------
// clk_div_odd_or : odd-ratio clock divider, 50% duty via posedge/negedge OR
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module clk_div_odd_or #(
  parameter int DIV_CLK = 9
) (
  input  wire  clk,
  input  wire  rst_n,
  output logic clk_div9
);

  if ((DIV_CLK < 3) || ((DIV_CLK % 2) == 0)) begin : g_bad_div
    $fatal(1, "clk_div_odd_or: DIV_CLK=%0d must be odd and >= 3", DIV_CLK);
  end

  localparam int               CNT_W   = $clog2(DIV_CLK);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_CLK - 1);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'((DIV_CLK - 1) / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clk_p;
  logic             clk_n;

  always_comb begin
    cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      clk_p <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (cnt_nxt == '0) begin
        clk_p <= 1'b1;
      end else if (cnt_nxt == HALF) begin
        clk_p <= 1'b0;
      end
    end
  end

  // Half-cycle delayed copy stretches the short posedge high phase by 0.5 clk.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      clk_n <= 1'b0;
    end else begin
      clk_n <= clk_p;
    end
  end

  assign clk_div9 = clk_p | clk_n;

`ifndef SYNTHESIS
  // Every phase after the first rise since reset must last DIV_CLK half-cycles.
  int   half_cnt;
  logic div_q;
  logic armed;

  always @(posedge clk or negedge clk) begin
    div_q <= clk_div9;
    if (!rst_n) begin
      armed    <= 1'b0;
      half_cnt <= 0;
    end else if (clk_div9 != div_q) begin
      if (armed) begin
        assert (half_cnt + 1 == DIV_CLK)
          else $error("clk_div9 phase lasted %0d half-cycles", half_cnt + 1);
      end
      armed    <= armed | clk_div9;
      half_cnt <= 0;
    end else begin
      half_cnt <= half_cnt + 1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_div_odd_or.sv
// ---------------------------------------------------------------------------
// tb_clk_div_odd_or : four divider instances (3,5,9,15) against a phase model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_clk_div_odd_or;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  clk_div_odd_or_if if3 ();
  clk_div_odd_or_if if5 ();
  clk_div_odd_or_if if9 ();
  clk_div_odd_or_if if15 ();

  clk_div_odd_or #(.DIV_CLK(3))  u_div3  (.clk(clk), .rst_n(rst_n), .clk_div9(if3.clk_div9));
  clk_div_odd_or #(.DIV_CLK(5))  u_div5  (.clk(clk), .rst_n(rst_n), .clk_div9(if5.clk_div9));
  clk_div_odd_or #(.DIV_CLK(9))  u_div9  (.clk(clk), .rst_n(rst_n), .clk_div9(if9.clk_div9));
  clk_div_odd_or #(.DIV_CLK(15)) u_div15 (.clk(clk), .rst_n(rst_n), .clk_div9(if15.clk_div9));

  logic [3:0] outs;
  assign outs = {if15.clk_div9, if9.clk_div9, if5.clk_div9, if3.clk_div9};

  always #0.5 clk = ~clk;

  function automatic int div_of(input int i);
    case (i)
      0:       return 3;
      1:       return 5;
      2:       return 9;
      default: return 15;
    endcase
  endfunction

  // p = posedges seen with rst_n high since release; output is high for the
  // first d half-cycles of each 2*d half-cycle period starting at posedge d.
  function automatic bit model(input int d, input int p, input bit neg_half);
    int h;
    if (p < d) return 1'b0;
    h = 2 * (p - d) + (neg_half ? 1 : 0);
    return (h % (2 * d)) < d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Continuous model comparison on both clock phases
  initial begin
    int p        = 0;
    int rst_post = 0;
    bit started  = 1'b0;
    bit r;
    forever begin
      @(posedge clk);
      r = rst_n;
      if (!r) begin
        rst_post++;
        p = 0;
      end else begin
        rst_post = 0;
        p++;
      end
      #0.1;
      if (started && !(!r && rst_post == 1)) begin
        for (int i = 0; i < 4; i++)
          chk($sformatf("model_pos_div%0d", div_of(i)), int'(outs[i]),
              r ? int'(model(div_of(i), p, 1'b0)) : 0);
      end
      @(negedge clk);
      r = rst_n;
      if (!r) started = 1'b1;
      #0.1;
      if (started) begin
        for (int i = 0; i < 4; i++)
          chk($sformatf("model_neg_div%0d", div_of(i)), int'(outs[i]),
              r ? int'(model(div_of(i), p, 1'b1)) : 0);
      end
    end
  end

  task automatic drive_rst(input logic v);
    @(negedge clk);
    #0.25;
    rst_n = v;
  endtask

  task automatic half_step();
    @(posedge clk or negedge clk);
    #0.1;
  endtask

  task automatic measure_startup(input string tag);
    int n;
    int hi;
    int lo;
    n = 0;
    do begin
      @(posedge clk);
      #0.1;
      n++;
    end while (!outs[2] && n < 40);
    chk({tag, "_first_rise"}, n, 9);
    hi = 1;
    half_step();
    while (outs[2] && hi < 40) begin
      hi++;
      half_step();
    end
    chk({tag, "_high_halves"}, hi, 9);
    lo = 1;
    half_step();
    while (!outs[2] && lo < 40) begin
      lo++;
      half_step();
    end
    chk({tag, "_low_halves"}, lo, 9);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  rises;
    int  n;
    bit  prev;

    // Reset hold
    repeat (10) begin
      @(negedge clk);
      #0.1;
      chk("rst_hold_outs", int'(outs), 0);
      chk("rst_hold_cnt", int'(u_div9.cnt), 0);
    end

    drive_rst(1'b1);
    measure_startup("startup");

    // Steady state over 200 clk cycles from a rising edge
    rises = 0;
    prev  = outs[2];
    repeat (400) begin
      half_step();
      if (outs[2] && !prev) rises++;
      prev = outs[2];
    end
    chk("steady_periods", rises, 22);

    // Reset in the middle of a high phase
    n = 0;
    while (!outs[2] && n < 40) begin
      half_step();
      n++;
    end
    chk("mid_rst_in_high", int'(outs[2]), 1);
    drive_rst(1'b0);
    @(negedge clk);
    #0.1;
    chk("mid_rst_low", int'(outs), 0);
    repeat (3) @(negedge clk);
    drive_rst(1'b1);
    measure_startup("restart");

    // Random run/reset pattern, checked by the model process
    repeat (30) begin
      repeat ($urandom_range(5, 120)) @(negedge clk);
      drive_rst(1'b0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      drive_rst(1'b1);
    end
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
